// File: rtl/elevator_pkg.sv
// Shared types, widths and helpers for the elevator controller.
package elevator_pkg;

    localparam int unsigned FLOOR_W          = 4;
    localparam int unsigned MAX_FLOORS       = 16;
    localparam int unsigned DEF_NUM_FLOORS   = 10;
    localparam int unsigned DEF_TRAVEL_TICKS = 3;
    localparam int unsigned DEF_DOOR_TICKS   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR_OPEN
    } state_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // True when any call is latched strictly above floor f.
    function automatic logic calls_above(input logic [MAX_FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0]    f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(MAX_FLOORS); i++) begin
            if (i > int'(f) && p[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when any call is latched strictly below floor f.
    function automatic logic calls_below(input logic [MAX_FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0]    f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(MAX_FLOORS); i++) begin
            if (i < int'(f) && p[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/elevator_controller_tick_counter.sv
// Wrapping up-counter: done_c flags the terminal count TICKS-1; load restarts at zero.
module tick_counter #(
    parameter int unsigned TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic done_c
);

    localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign done_c = (count_q == CNT_W'(TICKS - 1));

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (enable) begin
            count_d = done_c ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/elevator_controller.sv
// SCAN-order elevator controller with latched calls, travel and door timers.
// Optional emergency stop input is added when ELEVATOR_ESTOP_EN is defined.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = DEF_NUM_FLOORS,
    parameter int unsigned TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter int unsigned DOOR_TICKS   = DEF_DOOR_TICKS
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ELEVATOR_ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    state_e                  state_q, state_d;
    dir_e                    dir_q, dir_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic                    moving_up_q, moving_up_d;
    logic                    moving_down_q, moving_down_d;
    logic                    door_open_q, door_open_d;

    logic [MAX_FLOORS-1:0]   pend16;
    logic                    creq_here;
    logic                    frz_c;
    logic                    clr_en;
    logic [FLOOR_W-1:0]      clr_idx;
    logic                    trav_load, trav_en, trav_done_c;
    logic                    door_load, door_en, door_done_c;

`ifdef ELEVATOR_ESTOP_EN
    assign frz_c = estop;
`else
    assign frz_c = 1'b0;
`endif

    assign pend16 = MAX_FLOORS'(pending_q);

    // Button currently pressed at the cabin's own floor.
    always_comb begin
        creq_here = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (int'(floor_q) == i) creq_here = call_req[i];
        end
    end

    tick_counter #(.TICKS(TRAVEL_TICKS)) u_travel_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (trav_load),
        .enable (trav_en),
        .done_c (trav_done_c)
    );

    tick_counter #(.TICKS(DOOR_TICKS)) u_door_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (door_load),
        .enable (door_en),
        .done_c (door_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dir_q         <= DIR_UP;
            floor_q       <= '0;
            pending_q     <= '0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            floor_q       <= floor_d;
            pending_q     <= pending_d;
            moving_up_q   <= moving_up_d;
            moving_down_q <= moving_down_d;
            door_open_q   <= door_open_d;
        end
    end

    // Next state, floor, direction, timer control and call latching.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        floor_d   = floor_q;
        clr_en    = 1'b0;
        clr_idx   = floor_q;
        trav_load = 1'b0;
        door_load = 1'b0;
        trav_en   = !frz_c && (state_q == S_MOVE_UP || state_q == S_MOVE_DOWN);
        door_en   = !frz_c && (state_q == S_DOOR_OPEN);

        if (!frz_c) begin
            unique case (state_q)
                S_IDLE: begin
                    if (pend16[floor_q]) begin
                        state_d   = S_DOOR_OPEN;
                        clr_en    = 1'b1;
                        door_load = 1'b1;
                    end else if (calls_above(pend16, floor_q) &&
                                 (dir_q == DIR_UP || !calls_below(pend16, floor_q))) begin
                        state_d   = S_MOVE_UP;
                        dir_d     = DIR_UP;
                        trav_load = 1'b1;
                    end else if (calls_below(pend16, floor_q)) begin
                        state_d   = S_MOVE_DOWN;
                        dir_d     = DIR_DOWN;
                        trav_load = 1'b1;
                    end
                end
                S_MOVE_UP: begin
                    if (trav_done_c) begin
                        floor_d = floor_q + FLOOR_W'(1);
                        if (pend16[floor_d]) begin
                            state_d   = S_DOOR_OPEN;
                            clr_en    = 1'b1;
                            clr_idx   = floor_d;
                            door_load = 1'b1;
                        end else if (!calls_above(pend16, floor_d)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_MOVE_DOWN: begin
                    if (trav_done_c) begin
                        floor_d = floor_q - FLOOR_W'(1);
                        if (pend16[floor_d]) begin
                            state_d   = S_DOOR_OPEN;
                            clr_en    = 1'b1;
                            clr_idx   = floor_d;
                            door_load = 1'b1;
                        end else if (!calls_below(pend16, floor_d)) begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DOOR_OPEN: begin
                    if (creq_here) begin
                        door_load = 1'b1;
                    end else if (door_done_c) begin
                        if (dir_q == DIR_UP && calls_above(pend16, floor_q)) begin
                            state_d   = S_MOVE_UP;
                            trav_load = 1'b1;
                        end else if (dir_q == DIR_DOWN && calls_below(pend16, floor_q)) begin
                            state_d   = S_MOVE_DOWN;
                            trav_load = 1'b1;
                        end else if (dir_q == DIR_UP && calls_below(pend16, floor_q)) begin
                            state_d   = S_MOVE_DOWN;
                            dir_d     = DIR_DOWN;
                            trav_load = 1'b1;
                        end else if (dir_q == DIR_DOWN && calls_above(pend16, floor_q)) begin
                            state_d   = S_MOVE_UP;
                            dir_d     = DIR_UP;
                            trav_load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            endcase
        end

        // A served floor's clear wins over a press on the same edge.
        pending_d = pending_q;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (call_req[i] && !(state_q == S_DOOR_OPEN && int'(floor_q) == i))
                pending_d[i] = 1'b1;
            if (clr_en && int'(clr_idx) == i)
                pending_d[i] = 1'b0;
        end
    end

    // Moore outputs, registered from the next state.
    always_comb begin
        moving_up_d   = (state_d == S_MOVE_UP)   && !frz_c;
        moving_down_d = (state_d == S_MOVE_DOWN) && !frz_c;
        door_open_d   = (state_d == S_DOOR_OPEN);
    end

    assign floor       = floor_q;
    assign pending     = pending_q;
    assign moving_up   = moving_up_q;
    assign moving_down = moving_down_q;
    assign door_open   = door_open_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller: directed table, corner sequences, random vs model.
module tb_elevator_controller;

    localparam int NF = 10;
    localparam int TT = 3;
    localparam int DT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          estop;
    logic [NF-1:0] call_req;
    logic [3:0]    floor;
    logic          moving_up, moving_down, door_open;
    logic [NF-1:0] pending;

    always #5 clk = ~clk;

    elevator_controller #(.NUM_FLOORS(NF), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef ELEVATOR_ESTOP_EN
        .estop       (estop),
`endif
        .call_req    (call_req),
        .floor       (floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .pending     (pending)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_UP, M_DN, M_DOOR} mmode_e;
    mmode_e    m_mode  = M_IDLE;
    int        m_floor = 0;
    bit        m_dir_up = 1'b1;
    int        m_left  = 0;
    bit        m_stop  = 1'b0;
    bit [NF-1:0] m_pend = '0;

    function automatic bit any_above(input bit [NF-1:0] p, input int f);
        for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input bit [NF-1:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input bit r, input bit [NF-1:0] c, input bit s);
        bit [NF-1:0] old;
        int clr;
        bit ahead, behind;
        if (r) begin
            m_mode = M_IDLE; m_floor = 0; m_dir_up = 1'b1; m_left = 0; m_pend = '0; m_stop = 1'b0;
            return;
        end
        old = m_pend;
        clr = -1;
        m_stop = s;
        for (int i = 0; i < NF; i++)
            if (c[i] && !(m_mode == M_DOOR && i == m_floor)) m_pend[i] = 1'b1;
        if (!s) begin
            case (m_mode)
                M_IDLE: begin
                    if (old[m_floor]) begin
                        m_mode = M_DOOR; m_left = DT; clr = m_floor;
                    end else if (any_above(old, m_floor) && (m_dir_up || !any_below(old, m_floor))) begin
                        m_mode = M_UP; m_dir_up = 1'b1; m_left = TT;
                    end else if (any_below(old, m_floor)) begin
                        m_mode = M_DN; m_dir_up = 1'b0; m_left = TT;
                    end
                end
                M_UP, M_DN: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_floor += (m_mode == M_UP) ? 1 : -1;
                        if (old[m_floor]) begin
                            m_mode = M_DOOR; m_left = DT; clr = m_floor;
                        end else if (m_mode == M_UP ? any_above(old, m_floor) : any_below(old, m_floor)) begin
                            m_left = TT;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                M_DOOR: begin
                    if (c[m_floor]) begin
                        m_left = DT;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            ahead  = m_dir_up ? any_above(old, m_floor) : any_below(old, m_floor);
                            behind = m_dir_up ? any_below(old, m_floor) : any_above(old, m_floor);
                            if (behind && !ahead) m_dir_up = !m_dir_up;
                            if (ahead || behind) begin
                                m_mode = m_dir_up ? M_UP : M_DN; m_left = TT;
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
        if (clr >= 0) m_pend[clr] = 1'b0;
    endtask

    function automatic logic [16:0] model_vec();
        return {4'(m_floor), (m_mode == M_UP) && !m_stop, (m_mode == M_DN) && !m_stop,
                (m_mode == M_DOOR), m_pend};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {floor, moving_up, moving_down, door_open, pending};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_vec(input string name, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {floor,up,dn,door,pend}=%h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit [NF-1:0] c, input bit s);
        rst = r; call_req = c; estop = s;
        @(posedge clk);
        model_edge(r, c, s);
        #1;
        check_vec("model", dut_vec(), model_vec());
    endtask

    function automatic bit dut_idle();
        return !moving_up && !moving_down && !door_open && (pending == '0);
    endfunction

    task automatic run_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!dut_idle() && k < budget) begin step(1'b0, '0, 1'b0); k++; end
        check_int({name, " idle reached"}, int'(k < budget), 1);
    endtask

    task automatic run_door(input string name, input int budget);
        int k;
        k = 0;
        while (!door_open && k < budget) begin step(1'b0, '0, 1'b0); k++; end
        check_int({name, " door reached"}, int'(k < budget), 1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          r;
        bit [NF-1:0] c;
        logic [16:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic addv(input int n, input bit r, input bit [NF-1:0] c, input int f,
                        input bit up, input bit dn, input bit dr, input bit [NF-1:0] p);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.r = r; v.c = (i == 0) ? c : '0;
            v.exp = {4'(f), up, dn, dr, p};
            tbl.push_back(v);
        end
    endtask

    int          stops[$];
    int          max_fl, door_cnt, k;
    bit          prev_door;
    bit [NF-1:0] rc;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; call_req = '0; estop = 1'b0;

        // Reset, call 3 from 0, door 4 cycles; then same-floor call with 2-edge latency.
        addv(1, 1'b1, '0,       0, 0, 0, 0, '0);
        addv(1, 1'b0, 10'h008,  0, 0, 0, 0, 10'h008);
        addv(3, 1'b0, '0,       0, 1, 0, 0, 10'h008);
        addv(3, 1'b0, '0,       1, 1, 0, 0, 10'h008);
        addv(3, 1'b0, '0,       2, 1, 0, 0, 10'h008);
        addv(4, 1'b0, '0,       3, 0, 0, 1, '0);
        addv(1, 1'b0, '0,       3, 0, 0, 0, '0);
        addv(1, 1'b0, 10'h008,  3, 0, 0, 0, 10'h008);
        addv(4, 1'b0, '0,       3, 0, 0, 1, '0);
        addv(1, 1'b0, '0,       3, 0, 0, 0, '0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].c, 1'b0);
            check_vec($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
        end

        // Door restart: call at own floor during door cycle 3 gives 3+4 door cycles.
        step(1'b0, 10'h010, 1'b0);
        run_door("restart", 20);
        door_cnt = 1;
        step(1'b0, '0, 1'b0);      if (door_open) door_cnt++;
        step(1'b0, '0, 1'b0);      if (door_open) door_cnt++;
        step(1'b0, 10'h010, 1'b0);
        k = 0;
        while (door_open && k < 20) begin
            door_cnt++;
            check_int("restart pending[4]", int'(pending[4]), 0);
            step(1'b0, '0, 1'b0);
            k++;
        end
        check_int("restart door cycles", door_cnt, 7);
        check_int("restart floor", int'(floor), 4);

        // SCAN: moving up from 5 toward 8, calls at 7 and 2 -> stops 7, 8, 2.
        step(1'b0, 10'h020, 1'b0);
        run_idle("goto5", 40);
        step(1'b0, 10'h100, 1'b0);
        step(1'b0, '0, 1'b0);
        check_int("scan start floor", int'(floor), 5);
        check_int("scan start up", int'(moving_up), 1);
        step(1'b0, 10'h084, 1'b0);
        prev_door = 1'b0;
        k = 0;
        while (!dut_idle() && k < 200) begin
            step(1'b0, '0, 1'b0);
            if (door_open && !prev_door) stops.push_back(int'(floor));
            prev_door = door_open;
            k++;
        end
        check_int("scan stop count", stops.size(), 3);
        if (stops.size() == 3) begin
            check_int("scan stop0", stops[0], 7);
            check_int("scan stop1", stops[1], 8);
            check_int("scan stop2", stops[2], 2);
        end

        // Top floor boundary: 0 -> 9 -> 0.
        step(1'b0, 10'h001, 1'b0);
        run_idle("goto0", 60);
        check_int("at floor 0", int'(floor), 0);
        step(1'b0, 10'h200, 1'b0);
        max_fl = 0; stops.delete(); prev_door = 1'b0; k = 0;
        while (!dut_idle() && k < 200) begin
            step(1'b0, '0, 1'b0);
            if (int'(floor) > max_fl) max_fl = int'(floor);
            if (door_open && !prev_door) stops.push_back(int'(floor));
            prev_door = door_open;
            k++;
        end
        check_int("top max floor", max_fl, 9);
        check_int("top door floor", (stops.size() == 1) ? stops[0] : -1, 9);
        step(1'b0, 10'h001, 1'b0);
        run_idle("return0", 80);
        check_int("back at 0", int'(floor), 0);

        // Reset mid-travel at floor 6 discards the same-cycle call.
        step(1'b0, 10'h200, 1'b0);
        k = 0;
        while (!(floor == 4'd6 && moving_up) && k < 60) begin step(1'b0, '0, 1'b0); k++; end
        check_int("reached 6 moving", int'(k < 60), 1);
        step(1'b1, 10'h008, 1'b0);
        check_vec("reset mid-travel", dut_vec(), 17'h0);
        step(1'b0, '0, 1'b0);
        check_vec("after reset", dut_vec(), 17'h0);

        // Random sparse calls with rare resets against the model.
        for (int i = 0; i < 3000; i++) begin
            rc = '0;
            if ($urandom_range(0, 5) == 0) rc[$urandom_range(0, NF - 1)] = 1'b1;
            step($urandom_range(0, 699) == 0, rc, 1'b0);
        end

`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop for 5 cycles on arrival at floor 2 delays arrival at 3 by 5.
        step(1'b1, '0, 1'b0);
        step(1'b0, 10'h008, 1'b0);
        k = 0;
        while (!(floor == 4'd2 && moving_up) && k < 40) begin step(1'b0, '0, 1'b0); k++; end
        check_int("estop reach 2", int'(k < 40), 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1);
            check_int("estop floor hold", int'(floor), 2);
            check_int("estop up forced", int'(moving_up), 0);
        end
        k = 5;
        while (!door_open && k < 40) begin step(1'b0, '0, 1'b0); k++; end
        check_int("estop total delay", k, TT + 5);
        check_int("estop arrival floor", int'(floor), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
